// File: rtl/upg_boot_ctrl.sv
// UART-programming boot controller: debounced entry into programming mode, CPU/programmer
// reset generation, region-decoded write routing, word counting and out-of-range error flag.
module upg_boot_ctrl #(
   parameter int unsigned ADDR_W          = 15,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned NUM_REGIONS     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned HOLD_CYCLES     = 8,
   parameter int unsigned CNT_W           = 16,
   localparam int unsigned SEL_W          = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
   input  logic                    fpga_clk,
   input  logic                    fpga_rst,
   input  logic                    start_i,
   input  logic                    upg_wen_i,
   input  logic [ADDR_W-1:0]       upg_addr_i,
   input  logic [DATA_W-1:0]       upg_data_i,
   input  logic                    upg_done_i,
   output logic                    upg_rst_o,
   output logic                    cpu_rst_o,
   output logic [NUM_REGIONS-1:0]  mem_wen_o,
   output logic [ADDR_W-SEL_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0]       mem_data_o,
   output logic [CNT_W-1:0]        word_cnt_o,
   output logic                    prog_busy_o,
   output logic                    err_o
);

   localparam int unsigned LOW_W  = ADDR_W - SEL_W;
   localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [1:0] {ST_RUN, ST_PROG, ST_FLUSH} state_t;

   state_t              state_q, state_d;
   logic                start_meta, start_sync;
   logic [DEB_W-1:0]    deb_cnt, deb_d;
   logic                start_ok_c;
   logic [HOLD_W-1:0]   hold_cnt, hold_d;
   logic [SEL_W-1:0]    sel_c;
   logic                upg_rst_d, cpu_rst_d, busy_d, err_d;
   logic [NUM_REGIONS-1:0] mem_wen_d;
   logic [LOW_W-1:0]    mem_addr_d;
   logic [DATA_W-1:0]   mem_data_d;
   logic [CNT_W-1:0]    cnt_d;

   assign sel_c = upg_addr_i[ADDR_W-1 -: SEL_W];

   // Debounce: count synchronised-high cycles, pulse once on reaching the threshold, saturate.
   always_comb begin
      deb_d      = deb_cnt;
      start_ok_c = 1'b0;
      if (!start_sync) begin
         deb_d = '0;
      end else if (deb_cnt != DEB_W'(DEBOUNCE_CYCLES)) begin
         deb_d = deb_cnt + DEB_W'(1);
         if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) start_ok_c = 1'b1;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_cnt;
      upg_rst_d  = upg_rst_o;
      cpu_rst_d  = cpu_rst_o;
      busy_d     = prog_busy_o;
      err_d      = err_o;
      cnt_d      = word_cnt_o;
      mem_wen_d  = '0;
      mem_addr_d = mem_addr_o;
      mem_data_d = mem_data_o;
      case (state_q)
         ST_RUN: begin
            upg_rst_d = 1'b1;
            cpu_rst_d = 1'b0;
            busy_d    = 1'b0;
            if (start_ok_c) begin
               state_d   = ST_PROG;
               upg_rst_d = 1'b0;
               cpu_rst_d = 1'b1;
               busy_d    = 1'b1;
               cnt_d     = '0;
               err_d     = 1'b0;
            end
         end
         ST_PROG: begin
            upg_rst_d = 1'b0;
            cpu_rst_d = 1'b1;
            busy_d    = 1'b1;
            if (upg_wen_i) begin
               if (32'(sel_c) < NUM_REGIONS) begin
                  mem_wen_d  = NUM_REGIONS'(1) << sel_c;
                  mem_addr_d = upg_addr_i[LOW_W-1:0];
                  mem_data_d = upg_data_i;
                  if (word_cnt_o != {CNT_W{1'b1}}) cnt_d = word_cnt_o + CNT_W'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            if (upg_done_i) begin
               state_d = ST_FLUSH;
               hold_d  = '0;
            end
         end
         ST_FLUSH: begin
            upg_rst_d = 1'b0;
            cpu_rst_d = 1'b1;
            busy_d    = 1'b1;
            if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
               state_d   = ST_RUN;
               hold_d    = '0;
               upg_rst_d = 1'b1;
               cpu_rst_d = 1'b0;
               busy_d    = 1'b0;
            end else begin
               hold_d = hold_cnt + HOLD_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State and registered outputs; reset aborts any session and keeps the CPU held.
   always_ff @(posedge fpga_clk) begin
      if (fpga_rst) begin
         state_q     <= ST_RUN;
         start_meta  <= 1'b0;
         start_sync  <= 1'b0;
         deb_cnt     <= '0;
         hold_cnt    <= '0;
         upg_rst_o   <= 1'b1;
         cpu_rst_o   <= 1'b1;
         mem_wen_o   <= '0;
         mem_addr_o  <= '0;
         mem_data_o  <= '0;
         word_cnt_o  <= '0;
         prog_busy_o <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_meta  <= start_i;
         start_sync  <= start_meta;
         deb_cnt     <= deb_d;
         hold_cnt    <= hold_d;
         upg_rst_o   <= upg_rst_d;
         cpu_rst_o   <= cpu_rst_d;
         mem_wen_o   <= mem_wen_d;
         mem_addr_o  <= mem_addr_d;
         mem_data_o  <= mem_data_d;
         word_cnt_o  <= cnt_d;
         prog_busy_o <= busy_d;
         err_o       <= err_d;
      end
   end

endmodule
